// File: rtl/axi_rd_if.sv
// rtl/axi_rd_if.sv - AXI-lite read-channel (AR + R) bundle
interface axi_rd_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;

    // Requester side: issues addresses, consumes read data.
    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rresp, rdata
    );

    // Responder side: accepts addresses, returns read data.
    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master round-robin AXI-lite read arbiter with in-order R routing
module axi_rd_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int OT_LOG2 = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    axi_rd_if.slave   m0,
    axi_rd_if.slave   m1,
    axi_rd_if.master  s
);
    localparam int DEPTH = 1 << OT_LOG2;
    localparam int CNT_W = OT_LOG2 + 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } ar_state_e;

    ar_state_e           state_q, state_d;
    logic                lock_q, lock_d;
    logic                rr_last_q;
    logic [CNT_W-1:0]    ot_cnt_q, ot_cnt_d;
    logic [OT_LOG2-1:0]  wptr_q, rptr_q;
    logic [DEPTH-1:0]    fifo_q;

    logic                gnt, gnt_vld, req;
    logic                full, empty;
    logic                s_arvalid_w, ar_hs;
    logic                head, r_hs;
    logic [ADDR_W-1:0]   sel_araddr;
    logic [DATA_W-1:0]   rdata_w;

    assign full  = (ot_cnt_q == CNT_W'(DEPTH));
    assign empty = (ot_cnt_q == '0);

    // Grant selection and AR FSM next state; LOCK pins the grant until the slave accepts.
    always_comb begin
        gnt     = 1'b0;
        gnt_vld = 1'b0;
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                gnt_vld = m0.arvalid | m1.arvalid;
                gnt     = (m0.arvalid & m1.arvalid) ? ~rr_last_q : m1.arvalid;
            end
            LOCK: begin
                gnt_vld = 1'b1;
                gnt     = lock_q;
            end
            default: ;
        endcase
        req         = gnt ? m1.arvalid : m0.arvalid;
        s_arvalid_w = gnt_vld & req & ~full;
        ar_hs       = s_arvalid_w & s.arready;
        case (state_q)
            IDLE: begin
                if (s_arvalid_w && !s.arready) begin
                    state_d = LOCK;
                    lock_d  = gnt;
                end
            end
            LOCK: begin
                if (ar_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_araddr = gnt ? m1.araddr : m0.araddr;
    assign s.arvalid  = s_arvalid_w;
    assign s.araddr   = sel_araddr;
    assign m0.arready = s_arvalid_w & ~gnt & s.arready;
    assign m1.arready = s_arvalid_w &  gnt & s.arready;

    // R beats belong to whoever issued the oldest outstanding AR.
    assign head       = fifo_q[rptr_q];
    assign r_hs       = s.rvalid & s.rready;
    assign rdata_w    = s.rdata;
    assign s.rready   = ~empty & (head ? m1.rready : m0.rready);
    assign m0.rvalid  = ~empty & ~head & s.rvalid;
    assign m1.rvalid  = ~empty &  head & s.rvalid;
    assign m0.rresp   = s.rresp;
    assign m1.rresp   = s.rresp;
    assign m0.rdata   = rdata_w;
    assign m1.rdata   = rdata_w;

    // Outstanding count: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        ot_cnt_d = ot_cnt_q;
        if (ar_hs && !r_hs) begin
            ot_cnt_d = ot_cnt_q + CNT_W'(1);
        end else if (!ar_hs && r_hs) begin
            ot_cnt_d = ot_cnt_q - CNT_W'(1);
        end
    end

    // State, round-robin history and order FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_q    <= 1'b0;
            rr_last_q <= 1'b1;
            ot_cnt_q  <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            fifo_q    <= '0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            ot_cnt_q <= ot_cnt_d;
            if (ar_hs) begin
                fifo_q[wptr_q] <= gnt;
                wptr_q         <= wptr_q + 1'b1;
                rr_last_q      <= gnt;
            end
            if (r_hs) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for the two-master read arbiter
module tb_axi_rd_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_rd_if m0_if ();
    axi_rd_if m1_if ();
    axi_rd_if s_if ();

    axi_rd_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    logic [64:0] exp_ar[$];
    logic [66:0] exp_r[$];
    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic own, input logic [63:0] addr);
        if (own) begin
            m1_if.arvalid = 1'b1;
            m1_if.araddr  = addr;
        end else begin
            m0_if.arvalid = 1'b1;
            m0_if.araddr  = addr;
        end
        exp_ar.push_back({own, addr});
        step(1);
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
    endtask

    task automatic beat(input logic own, input logic [1:0] resp, input logic [63:0] data);
        s_if.rvalid = 1'b1;
        s_if.rresp  = resp;
        s_if.rdata  = data;
        exp_r.push_back({own, resp, data});
        step(1);
        s_if.rvalid = 1'b0;
    endtask

    // Monitor: every slave-side handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        logic [64:0] ea;
        logic [66:0] er;
        logic        own;
        if (rst_n) begin
            if (s_if.arvalid && s_if.arready) begin
                chk("ar_onehot", 64'(m0_if.arready ^ m1_if.arready), 64'd1);
                if (exp_ar.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL ar_unexpected: got addr %h expected no AR", s_if.araddr);
                end else begin
                    ea = exp_ar.pop_front();
                    chk("ar_owner", 64'(m1_if.arready), 64'(ea[64]));
                    chk("ar_addr", s_if.araddr, ea[63:0]);
                end
            end
            if (s_if.rvalid && s_if.rready) begin
                chk("r_onehot", 64'(m0_if.rvalid ^ m1_if.rvalid), 64'd1);
                own = m1_if.rvalid;
                if (exp_r.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL r_unexpected: got data %h expected no beat", s_if.rdata);
                end else begin
                    er = exp_r.pop_front();
                    chk("r_owner", 64'(own), 64'(er[66]));
                    chk("r_resp", 64'(own ? m1_if.rresp : m0_if.rresp), 64'(er[65:64]));
                    chk("r_data", own ? m1_if.rdata : m0_if.rdata, er[63:0]);
                end
            end
        end
    end

    initial begin
        m0_if.arvalid = 1'b0; m0_if.araddr = '0; m0_if.rready = 1'b0;
        m1_if.arvalid = 1'b0; m1_if.araddr = '0; m1_if.rready = 1'b0;
        s_if.arready  = 1'b0; s_if.rvalid  = 1'b0; s_if.rresp  = '0; s_if.rdata = '0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Reset state: everything quiet, even with slave readies/valids up.
        s_if.arready = 1'b1;
        s_if.rvalid  = 1'b1;
        #1;
        chk("rst_s_arvalid", 64'(s_if.arvalid), 64'd0);
        chk("rst_m0_arready", 64'(m0_if.arready), 64'd0);
        chk("rst_m1_arready", 64'(m1_if.arready), 64'd0);
        chk("rst_s_rready", 64'(s_if.rready), 64'd0);
        chk("rst_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
        chk("rst_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
        s_if.rvalid = 1'b0;
        step(1);

        // 1: four back-to-back m0 ARs fill the FIFO; the fifth stalls.
        m0_if.arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m0_if.araddr = 64'h100 + 64'(8 * k);
            exp_ar.push_back({1'b0, m0_if.araddr});
            step(1);
        end
        m0_if.araddr = 64'h120;
        #1;
        chk("t1_full_s_arvalid", 64'(s_if.arvalid), 64'd0);
        chk("t1_full_m0_arready", 64'(m0_if.arready), 64'd0);
        step(1);
        chk("t1_full_hold", 64'(s_if.arvalid), 64'd0);
        m0_if.arvalid = 1'b0;
        m0_if.rready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            beat(1'b0, 2'(k), 64'hD0 + 64'(k));
        end
        s_if.rvalid = 1'b1;
        #1;
        chk("t1_empty_s_rready", 64'(s_if.rready), 64'd0);
        chk("t1_empty_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
        s_if.rvalid = 1'b0;

        // Mid-operation reset clears outstanding entries immediately.
        issue(1'b0, 64'h400);
        issue(1'b0, 64'h408);
        s_if.rvalid = 1'b1;
        #1;
        chk("mr_pre_m0_rvalid", 64'(m0_if.rvalid), 64'd1);
        s_if.rvalid = 1'b0;
        exp_ar.delete();
        rst_n = 1'b0;
        #1;
        s_if.rvalid = 1'b1;
        #1;
        chk("mr_s_rready", 64'(s_if.rready), 64'd0);
        chk("mr_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
        s_if.rvalid = 1'b0;
        rst_n = 1'b1;
        step(1);

        // 2: both request from reset -> m0,m1,m0,m1.
        m0_if.arvalid = 1'b1; m0_if.araddr = 64'hA00;
        m1_if.arvalid = 1'b1; m1_if.araddr = 64'hB00;
        exp_ar.push_back({1'b0, 64'hA00});
        exp_ar.push_back({1'b1, 64'hB00});
        exp_ar.push_back({1'b0, 64'hA00});
        exp_ar.push_back({1'b1, 64'hB00});
        step(4);
        chk("t2_full", 64'(s_if.arvalid), 64'd0);
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
        m1_if.rready  = 1'b1;
        beat(1'b0, 2'd0, 64'h20);
        beat(1'b1, 2'd0, 64'h21);
        beat(1'b0, 2'd2, 64'h22);
        beat(1'b1, 2'd0, 64'h23);

        // 3: m1 locked while the slave stalls; m0 waits its turn.
        s_if.arready  = 1'b0;
        m1_if.arvalid = 1'b1; m1_if.araddr = 64'h2000;
        step(1);
        chk("t3_lock_s_arvalid", 64'(s_if.arvalid), 64'd1);
        chk("t3_lock_addr0", s_if.araddr, 64'h2000);
        m0_if.arvalid = 1'b1; m0_if.araddr = 64'h3000;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t3_lock_addr", s_if.araddr, 64'h2000);
            chk("t3_lock_m0_arready", 64'(m0_if.arready), 64'd0);
            step(1);
        end
        s_if.arready = 1'b1;
        #1;
        chk("t3_m1_arready", 64'(m1_if.arready), 64'd1);
        exp_ar.push_back({1'b1, 64'h2000});
        step(1);
        m1_if.arvalid = 1'b0;
        exp_ar.push_back({1'b0, 64'h3000});
        step(1);
        m0_if.arvalid = 1'b0;
        beat(1'b1, 2'd0, 64'h31);
        beat(1'b0, 2'd0, 64'h30);

        // 4: issue order determines R routing.
        issue(1'b0, 64'h8000_0000);
        issue(1'b1, 64'h1000);
        s_if.rvalid = 1'b1;
        #1;
        chk("t4_first_m0", 64'(m0_if.rvalid), 64'd1);
        chk("t4_first_m1", 64'(m1_if.rvalid), 64'd0);
        beat(1'b0, 2'd0, 64'h1111);
        s_if.rvalid = 1'b1;
        #1;
        chk("t4_second_m0", 64'(m0_if.rvalid), 64'd0);
        chk("t4_second_m1", 64'(m1_if.rvalid), 64'd1);
        beat(1'b1, 2'd0, 64'h2222);

        // 5: at three outstanding, AR and R in the same cycle keep the count at three.
        issue(1'b0, 64'h500);
        issue(1'b0, 64'h508);
        issue(1'b0, 64'h510);
        m1_if.arvalid = 1'b1; m1_if.araddr = 64'h5000;
        exp_ar.push_back({1'b1, 64'h5000});
        #1;
        chk("t5_m1_arready", 64'(m1_if.arready), 64'd1);
        beat(1'b0, 2'd0, 64'h5555);
        m1_if.arvalid = 1'b0;
        m0_if.arvalid = 1'b1; m0_if.araddr = 64'h6000;
        #1;
        chk("t5_further_ar", 64'(m0_if.arready), 64'd1);
        exp_ar.push_back({1'b0, 64'h6000});
        step(1);
        m0_if.araddr = 64'h6008;
        #1;
        chk("t5_now_full", 64'(s_if.arvalid), 64'd0);
        m0_if.arvalid = 1'b0;
        beat(1'b0, 2'd0, 64'h51);
        beat(1'b0, 2'd0, 64'h52);
        beat(1'b1, 2'd0, 64'h53);
        beat(1'b0, 2'd0, 64'h54);

        // 6: head master not ready holds the beat on the slave.
        issue(1'b0, 64'h7000);
        m0_if.rready = 1'b0;
        s_if.rvalid  = 1'b1;
        s_if.rdata   = 64'h7777;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t6_s_rready", 64'(s_if.rready), 64'd0);
            chk("t6_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
            chk("t6_m0_rvalid", 64'(m0_if.rvalid), 64'd1);
            step(1);
        end
        m0_if.rready = 1'b1;
        beat(1'b0, 2'd0, 64'h7777);
        step(2);

        chk("end_exp_ar_empty", 64'(exp_ar.size()), 64'd0);
        chk("end_exp_r_empty", 64'(exp_r.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
